// File: rtl/id_stage_pkg.sv
// Shared constants and helpers for the decode front end.
// This covers instruction field positions, the NOP encoding and thread-index sizing.
package id_stage_pkg;

    localparam int REG_IDX_W = 5;
    localparam int NUM_REGS  = 32;

    localparam int RD_LSB  = 7;
    localparam int RS1_LSB = 15;
    localparam int RS2_LSB = 20;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // A single-thread build still needs a one-bit thread id.
    function automatic int calc_bits_threads(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/id_stage_if.sv
// Bundles the fetch, execute-redirect, writeback and decode-output signals of id_stage.
// The master modport is the pipeline around the stage; the slave modport is id_stage itself.
interface id_stage_if
    import id_stage_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32,
    parameter int NUM_THREADS   = 8
);
    localparam int BITS_THREADS = calc_bits_threads(NUM_THREADS);

    logic [ADDRESS_WIDTH-1:0] pc_f;
    logic [ADDRESS_WIDTH-1:0] pc_plus4_f;
    logic [DATA_WIDTH-1:0]    instr_f;
    logic [BITS_THREADS-1:0]  tid_f;
    logic                     stall_d;
    logic                     pc_src_e;
    logic [BITS_THREADS-1:0]  tid_e;
    logic                     reg_write_w;
    logic [BITS_THREADS-1:0]  tid_w;
    logic [REG_IDX_W-1:0]     rd_w;
    logic [DATA_WIDTH-1:0]    result_w;

    logic                     valid_d;
    logic [ADDRESS_WIDTH-1:0] pc_d;
    logic [ADDRESS_WIDTH-1:0] pc_plus4_d;
    logic [DATA_WIDTH-1:0]    instr_d;
    logic [BITS_THREADS-1:0]  tid_d;
    logic [REG_IDX_W-1:0]     rs1_d;
    logic [REG_IDX_W-1:0]     rs2_d;
    logic [REG_IDX_W-1:0]     rd_d;
    logic [DATA_WIDTH-1:0]    rd1_d;
    logic [DATA_WIDTH-1:0]    rd2_d;

    modport master (
        output pc_f, pc_plus4_f, instr_f, tid_f, stall_d, pc_src_e, tid_e,
               reg_write_w, tid_w, rd_w, result_w,
        input  valid_d, pc_d, pc_plus4_d, instr_d, tid_d, rs1_d, rs2_d, rd_d,
               rd1_d, rd2_d
    );

    modport slave (
        input  pc_f, pc_plus4_f, instr_f, tid_f, stall_d, pc_src_e, tid_e,
               reg_write_w, tid_w, rd_w, result_w,
        output valid_d, pc_d, pc_plus4_d, instr_d, tid_d, rs1_d, rs2_d, rd_d,
               rd1_d, rd2_d
    );

endinterface

// File: rtl/id_stage_mt_regfile.sv
// Banked per-thread integer register file with one write port and two combinational read ports.
// x0 always reads zero, and a matching same-cycle writeback is forwarded to the readers.
module mt_regfile
    import id_stage_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_THREADS  = 8,
    parameter int BITS_THREADS = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_we,
    input  logic [BITS_THREADS-1:0] i_wtid,
    input  logic [REG_IDX_W-1:0]    i_wrd,
    input  logic [DATA_WIDTH-1:0]   i_wdata,
    input  logic [BITS_THREADS-1:0] i_rtid,
    input  logic [REG_IDX_W-1:0]    i_rs1,
    input  logic [REG_IDX_W-1:0]    i_rs2,
    output logic [DATA_WIDTH-1:0]   o_rd1,
    output logic [DATA_WIDTH-1:0]   o_rd2
);
    // Banks are sized to a power of two so {tid, reg} always addresses a real entry.
    localparam int DEPTH = (2 ** BITS_THREADS) * NUM_REGS;

    logic [DATA_WIDTH-1:0] r_bank [DEPTH];
    logic                  w_we_eff;
    logic [REG_IDX_W-1:0]  w_rs [2];
    logic [DATA_WIDTH-1:0] w_rd [2];

    assign w_we_eff = i_we && (i_wrd != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_bank[i] <= '0;
            end
        end else if (w_we_eff) begin
            r_bank[{i_wtid, i_wrd}] <= i_wdata;
        end
    end

    assign w_rs[0] = i_rs1;
    assign w_rs[1] = i_rs2;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_read
            assign w_rd[gi] = (w_rs[gi] == '0) ? '0 :
                              (w_we_eff && (i_wtid == i_rtid) && (i_wrd == w_rs[gi])) ? i_wdata :
                              r_bank[{i_rtid, w_rs[gi]}];
        end
    endgenerate

    assign o_rd1 = w_rd[0];
    assign o_rd2 = w_rd[1];

endmodule

// File: rtl/id_stage.sv
// IF/ID pipeline register with a per-thread squash on execute redirects.
// It feeds the banked register file and presents the decode-side fields and operands.
module id_stage
    import id_stage_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32,
    parameter int NUM_THREADS   = 8
) (
    input logic    clk,
    input logic    rst,
    id_stage_if.slave bus
);
    localparam int BITS_THREADS = calc_bits_threads(NUM_THREADS);

    logic                     r_valid;
    logic [ADDRESS_WIDTH-1:0] r_pc;
    logic [ADDRESS_WIDTH-1:0] r_pc_plus4;
    logic [DATA_WIDTH-1:0]    r_instr;
    logic [BITS_THREADS-1:0]  r_tid;

    logic                     w_squash_f;
    logic                     w_squash_d;
    logic [DATA_WIDTH-1:0]    w_instr;

    // A redirect kills only the instruction that belongs to the redirecting thread.
    assign w_squash_f = bus.pc_src_e && (bus.tid_e == bus.tid_f);
    assign w_squash_d = bus.pc_src_e && (bus.tid_e == r_tid);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid    <= 1'b0;
            r_pc       <= '0;
            r_pc_plus4 <= '0;
            r_instr    <= DATA_WIDTH'(NOP_INSTR);
            r_tid      <= '0;
        end else if (bus.stall_d) begin
            r_valid    <= r_valid && !w_squash_d;
        end else begin
            r_valid    <= !w_squash_f;
            r_pc       <= bus.pc_f;
            r_pc_plus4 <= bus.pc_plus4_f;
            r_instr    <= bus.instr_f;
            r_tid      <= bus.tid_f;
        end
    end

    assign w_instr = r_valid ? r_instr : DATA_WIDTH'(NOP_INSTR);

    assign bus.valid_d    = r_valid;
    assign bus.pc_d       = r_pc;
    assign bus.pc_plus4_d = r_pc_plus4;
    assign bus.instr_d    = w_instr;
    assign bus.tid_d      = r_tid;
    assign bus.rs1_d      = w_instr[RS1_LSB +: REG_IDX_W];
    assign bus.rs2_d      = w_instr[RS2_LSB +: REG_IDX_W];
    assign bus.rd_d       = w_instr[RD_LSB +: REG_IDX_W];

    mt_regfile #(
        .DATA_WIDTH   (DATA_WIDTH),
        .NUM_THREADS  (NUM_THREADS),
        .BITS_THREADS (BITS_THREADS)
    ) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .i_we    (bus.reg_write_w),
        .i_wtid  (bus.tid_w),
        .i_wrd   (bus.rd_w),
        .i_wdata (bus.result_w),
        .i_rtid  (r_tid),
        .i_rs1   (bus.rs1_d),
        .i_rs2   (bus.rs2_d),
        .o_rd1   (bus.rd1_d),
        .o_rd2   (bus.rd2_d)
    );

endmodule
